// File: rtl/ram64_stream_reader_pkg.sv
// Shared constants and state encoding for the 64-word RAM burst reader.
package ram64_stream_reader_pkg;

  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ram64_stream_reader_if.sv
// Output stream bundle of the burst reader.
// Handshake: a word moves on a rising edge where OVLD and ORDY are both 1; while
// OVLD=1 and ORDY=0 the master holds OD/OLAST stable, and OLAST is meaningful only with OVLD.
interface ram64_stream_reader_if #(
  parameter int DW = ram64_stream_reader_pkg::DW
);

  logic [DW-1:0] OD;
  logic          OVLD;
  logic          ORDY;
  logic          OLAST;

  modport master (output OD, output OVLD, output OLAST, input ORDY);
  modport slave  (input OD, input OVLD, input OLAST, output ORDY);

endinterface

// File: rtl/ram64_rd_ctr.sv
// Next-fetch address and remaining-word counter; both wrap modulo 2^AW.
module ram64_rd_ctr #(
  parameter int AW = ram64_stream_reader_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [AW-1:0] ld_addr,
  input  logic [AW-1:0] ld_cnt,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          zero
);

  logic [AW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      cnt  <= '0;
    end else if (ld) begin
      addr <= ld_addr;
      cnt  <= ld_cnt;
    end else if (step) begin
      addr <= addr + 1'b1;
      cnt  <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ram64_stream_reader.sv
// Burst reader: streams LEN+1 consecutive words from an external async-read RAM,
// starting at SA, through a one-word output register with valid/ready flow control.
module ram64_stream_reader #(
  parameter int AW = ram64_stream_reader_pkg::AW,
  parameter int DW = ram64_stream_reader_pkg::DW
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            START,
  input  logic [AW-1:0]                   SA,
  input  logic [AW-1:0]                   LEN,
  input  logic                            ABORT,
  output logic [AW-1:0]                   AB,
  input  logic [DW-1:0]                   YB,
  output logic                            BUSY,
  output ram64_stream_reader_pkg::state_t dbg_state,
  ram64_stream_reader_if.master           os
);

  import ram64_stream_reader_pkg::*;

  state_t        state;
  logic [DW-1:0] od;
  logic          ovld;
  logic          olast;
  logic          more;
  logic          start_ok;
  logic          load_run;
  logic [AW-1:0] addr;
  logic          zero;

  // The START edge already captures mem[SA] through the AB bypass, so the
  // counter is loaded one word ahead: addr holds the next address to fetch.
  always_comb begin
    start_ok = (state == IDLE) && START && !ABORT;
    load_run = (state == RUN) && !ABORT && more && (!ovld || os.ORDY);
    AB       = (state == IDLE) ? SA : addr;
  end

  ram64_rd_ctr #(.AW(AW)) u_ctr (
    .clk     (CLK),
    .rst     (RST),
    .ld      (start_ok),
    .ld_addr (SA + 1'b1),
    .ld_cnt  (LEN - 1'b1),
    .step    (load_run),
    .addr    (addr),
    .zero    (zero)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      od    <= '0;
      ovld  <= 1'b0;
      olast <= 1'b0;
      more  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            state <= RUN;
            od    <= YB;
            ovld  <= 1'b1;
            olast <= (LEN == '0);
            more  <= (LEN != '0);
          end
        end
        RUN: begin
          if (ABORT) begin
            state <= IDLE;
            ovld  <= 1'b0;
            olast <= 1'b0;
            more  <= 1'b0;
          end else if (load_run) begin
            od    <= YB;
            ovld  <= 1'b1;
            olast <= zero;
            more  <= !zero;
          end else if (ovld && os.ORDY) begin
            ovld <= 1'b0;
            if (olast) begin
              olast <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign os.OD    = od;
  assign os.OVLD  = ovld;
  assign os.OLAST = olast;
  assign BUSY     = (state == RUN);
  assign dbg_state = state;

endmodule

// File: tb/tb_ram64_stream_reader.sv
// Directed bench for ram64_stream_reader with a behavioural 64x16 RAM model.
module tb_ram64_stream_reader;

  import ram64_stream_reader_pkg::*;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic [5:0]    SA = '0;
  logic [5:0]    LEN = '0;
  logic          ABORT = 1'b0;
  logic [5:0]    AB;
  logic [15:0]   YB;
  logic          BUSY;
  state_t        dbg_state;

  logic          we = 1'b0;
  logic [5:0]    wa = '0;
  logic [15:0]   wd = '0;
  logic [15:0]   mem [64];

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  ram64_stream_reader_if #(.DW(16)) os_if ();

  ram64_stream_reader #(.AW(6), .DW(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .SA        (SA),
    .LEN       (LEN),
    .ABORT     (ABORT),
    .AB        (AB),
    .YB        (YB),
    .BUSY      (BUSY),
    .dbg_state (dbg_state),
    .os        (os_if)
  );

  // clock / RAM model
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (we) mem[wa] <= wd;
  end

  assign YB = mem[AB];

  // driver / check tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input int sa, input int len);
    for (int i = 0; i <= len; i++) exp_q.push_back(16'h1000 + 16'((sa + i) % 64));
  endtask

  // Called right after the START edge; consumes exp_q, checking order, OLAST and hold stability.
  task automatic drain(input string tag, input int max_cyc, input bit toggle, input int exp_cyc);
    bit          hold;
    logic [15:0] hold_od;
    int          c;
    hold = 1'b0;
    hold_od = '0;
    c = 0;
    while (exp_q.size() > 0 && c < max_cyc) begin
      os_if.ORDY = toggle ? ((c % 2) == 0) : 1'b1;
      if (hold) check({tag, "_stable"}, os_if.OD, hold_od);
      if (os_if.OVLD && os_if.ORDY) begin
        check({tag, "_data"}, os_if.OD, exp_q[0]);
        check({tag, "_last"}, os_if.OLAST, (exp_q.size() == 1) ? 1 : 0);
        void'(exp_q.pop_front());
        hold = 1'b0;
      end else if (os_if.OVLD) begin
        hold = 1'b1;
        hold_od = os_if.OD;
      end else begin
        check({tag, "_gap"}, os_if.OVLD, 1);
      end
      tick();
      c++;
    end
    check({tag, "_leftover"}, exp_q.size(), 0);
    exp_q.delete();
    if (exp_cyc > 0) check({tag, "_cycles"}, c, exp_cyc);
    os_if.ORDY = 1'b1;
    check({tag, "_busy_end"}, BUSY, 0);
    check({tag, "_ovld_end"}, os_if.OVLD, 0);
  endtask

  task automatic do_start(input int sa, input int len);
    SA = 6'(sa);
    LEN = 6'(len);
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  initial begin
    os_if.ORDY = 1'b1;
    // Preload mem[k] = 0x1000 + k through the write port while in reset.
    #1;
    for (int k = 0; k < 64; k++) begin
      we = 1'b1;
      wa = 6'(k);
      wd = 16'h1000 + 16'(k);
      tick();
    end
    we = 1'b0;
    tick();
    check("rst_ovld", os_if.OVLD, 0);
    check("rst_olast", os_if.OLAST, 0);
    check("rst_busy", BUSY, 0);
    check("rst_od", os_if.OD, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    RST = 1'b0;
    SA = 6'd9;
    #1;
    check("idle_ab_bypass", AB, 9);

    // Basic burst: four words on consecutive cycles.
    SA = 6'd5;
    LEN = 6'd3;
    START = 1'b1;
    tick();
    START = 1'b0;
    check("b1_first_ovld", os_if.OVLD, 1);
    check("b1_first_od", os_if.OD, 16'h1005);
    check("b1_busy", BUSY, 1);
    check("b1_state", 32'(dbg_state), 32'(RUN));
    push_seq(5, 3);
    drain("b1", 20, 1'b0, 4);

    // Wrap-around.
    do_start(62, 3);
    exp_q.push_back(16'h103E);
    exp_q.push_back(16'h103F);
    exp_q.push_back(16'h1000);
    exp_q.push_back(16'h1001);
    drain("wrap", 20, 1'b0, 4);

    // Full 64-word burst with ORDY toggling.
    do_start(0, 63);
    push_seq(0, 63);
    drain("full", 400, 1'b1, 0);

    // Abort on the third output cycle, then a single-word burst.
    do_start(10, 20);
    check("ab_w1", os_if.OD, 16'h100A);
    tick();
    check("ab_w2", os_if.OD, 16'h100B);
    tick();
    check("ab_w3", os_if.OD, 16'h100C);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check("ab_ovld", os_if.OVLD, 0);
    check("ab_busy", BUSY, 0);
    check("ab_olast", os_if.OLAST, 0);
    do_start(0, 0);
    exp_q.push_back(16'h1000);
    drain("single", 10, 1'b0, 1);

    // START held high while busy and on the final transfer: all ignored.
    do_start(20, 2);
    START = 1'b1;
    SA = 6'd40;
    LEN = 6'd5;
    push_seq(20, 2);
    drain("busy_start", 20, 1'b0, 3);
    START = 1'b0;
    tick();
    check("busy_start_noextra", os_if.OVLD, 0);
    check("busy_start_idle", BUSY, 0);

    // Reset mid-burst.
    do_start(30, 10);
    tick();
    RST = 1'b1;
    tick();
    check("mrst_ovld", os_if.OVLD, 0);
    check("mrst_olast", os_if.OLAST, 0);
    check("mrst_busy", BUSY, 0);
    check("mrst_od", os_if.OD, 0);
    check("mrst_state", 32'(dbg_state), 32'(IDLE));
    // Reset beats a coincident START.
    START = 1'b1;
    SA = 6'd3;
    tick();
    check("rst_start_busy", BUSY, 0);
    RST = 1'b0;
    START = 1'b0;
    tick();
    check("rst_start_ovld", os_if.OVLD, 0);

    // Write on the capture edge yields pre-write data; later read sees new data.
    os_if.ORDY = 1'b0;
    we = 1'b1;
    wa = 6'd7;
    wd = 16'hBEEF;
    do_start(7, 0);
    we = 1'b0;
    check("wr_old_od", os_if.OD, 16'h1007);
    check("wr_old_last", os_if.OLAST, 1);
    os_if.ORDY = 1'b1;
    tick();
    check("wr_done", BUSY, 0);
    do_start(6, 1);
    exp_q.push_back(16'h1006);
    exp_q.push_back(16'hBEEF);
    drain("wr_new", 10, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
